// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver: FSM state encoding and parity modes.
package rs232_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/rs232_rx_front.sv
// Line front end: two-flop synchronizer for the asynchronous rx pin plus a
// falling-edge detector on the synchronized line. Flops reset to the idle level.
module rs232_rx_front (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_s_nedge
);

  logic meta;
  logic rx_s_d;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      meta   <= rx;
      rx_s   <= meta;
      rx_s_d <= rx_s;
    end
  end

  assign rx_s_nedge = rx_s_d & ~rx_s;

endmodule

// File: rtl/rs232_rx_cfg.sv
// Configurable RS-232 receiver: start/data/parity/stop framing, break detection
// and a one-cycle write strobe into a downstream FIFO.
//
// FIFO handshake: rx_fifo_wr_en is a single-cycle push, issued the cycle after
// the last stop sample. rx_fifo_full is sampled at that last stop sample; if it
// is high the character is dropped (err_overrun) and never retried.
module rs232_rx_cfg
  import rs232_pkg::*;
#(
  parameter int P_CLKS_PER_BIT = 20,
  parameter int P_DATA_BITS    = 8,
  parameter int P_PARITY       = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [P_DATA_BITS-1:0] rx_fifo_data,
  output logic                   rx_fifo_wr_en,
  input  logic                   rx_fifo_full,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   err_overrun,
  output logic                   rx_break,
  output rx_state_t              dbg_state
);

  localparam int              CW        = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(P_CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(P_CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [3:0]      DATA_LAST = 4'(P_DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(P_STOP_BITS - 1);
  localparam logic            ODD_MODE  = (P_PARITY == PAR_ODD);

  logic rx_s;
  logic rx_s_nedge;

  rx_state_t              state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [3:0]             bit_cnt, bit_nx;
  logic [P_DATA_BITS-1:0] shreg, shreg_nx;
  logic [P_DATA_BITS-1:0] data_nx;
  logic                   par_bit, par_nx;
  logic                   stop_low, stop_low_nx;
  logic                   wr_nx, perr_nx, ferr_nx, ovr_nx, brk_nx;
  logic                   any_low, is_break, mismatch;

  rs232_rx_front u_front (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_s       (rx_s),
    .rx_s_nedge (rx_s_nedge)
  );

  // Next-state, sampling and end-of-character decisions.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_nx      = bit_cnt;
    shreg_nx    = shreg;
    par_nx      = par_bit;
    stop_low_nx = stop_low;
    data_nx     = rx_fifo_data;
    wr_nx       = 1'b0;
    perr_nx     = 1'b0;
    ferr_nx     = 1'b0;
    ovr_nx      = 1'b0;
    brk_nx      = 1'b0;
    // A low stop bit with an all-zero character (and zero parity) is a break.
    any_low     = stop_low | ~rx_s;
    is_break    = any_low && (shreg == '0) && ((P_PARITY == PAR_NONE) || !par_bit);
    mismatch    = ((^shreg) ^ par_bit) != ODD_MODE;
    case (state)
      S_IDLE: begin
        cnt_nx      = '0;
        bit_nx      = '0;
        stop_low_nx = 1'b0;
        par_nx      = 1'b0;
        if (rx_s_nedge) state_nx = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[P_DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_nx   = '0;
            state_nx = (P_PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_nx = bit_cnt + 4'd1;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          par_nx   = rx_s;
          state_nx = S_STOP;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx      = '0;
          stop_low_nx = any_low;
          if (bit_cnt == STOP_LAST) begin
            bit_nx = '0;
            if (any_low) begin
              brk_nx   = is_break;
              ferr_nx  = ~is_break;
              state_nx = is_break ? S_BRK : S_IDLE;
            end else begin
              state_nx = S_IDLE;
              if (rx_fifo_full) begin
                ovr_nx = 1'b1;
              end else begin
                wr_nx   = 1'b1;
                data_nx = shreg;
                perr_nx = (P_PARITY != PAR_NONE) && mismatch;
              end
            end
          end else begin
            bit_nx = bit_cnt + 4'd1;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_BRK: begin
        cnt_nx = '0;
        bit_nx = '0;
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      stop_low      <= 1'b0;
      rx_fifo_data  <= '0;
      rx_fifo_wr_en <= 1'b0;
      err_parity    <= 1'b0;
      err_frame     <= 1'b0;
      err_overrun   <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      bit_cnt       <= bit_nx;
      shreg         <= shreg_nx;
      par_bit       <= par_nx;
      stop_low      <= stop_low_nx;
      rx_fifo_data  <= data_nx;
      rx_fifo_wr_en <= wr_nx;
      err_parity    <= perr_nx;
      err_frame     <= ferr_nx;
      err_overrun   <= ovr_nx;
      rx_break      <= brk_nx;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rs232_rx_cfg.sv
// Bench for rs232_rx_cfg: an 8N1 instance (a) and a 7E2 instance (b), both at
// 16 clocks per bit, driven with directed and random frames.
module tb_rs232_rx_cfg;
  import rs232_pkg::*;

  localparam int CPB = 16;
  localparam int EW  = 14;  // {wr, perr, ferr, ovr, brk, data[8:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic full_a = 1'b0, full_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic wr_a, perr_a, ferr_a, ovr_a, brk_a;
  logic wr_b, perr_b, ferr_b, ovr_b, brk_b;
  rx_state_t dbg_a, dbg_b;

  logic [EW-1:0] obs_a_q[$], obs_b_q[$], exp_a_q[$], exp_b_q[$];
  logic [7:0] last_a = 8'h00;
  logic [6:0] last_b = 7'h00;
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rs232_rx_cfg #(.P_CLKS_PER_BIT(CPB), .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_fifo_data(data_a), .rx_fifo_wr_en(wr_a),
    .rx_fifo_full(full_a), .err_parity(perr_a), .err_frame(ferr_a), .err_overrun(ovr_a),
    .rx_break(brk_a), .dbg_state(dbg_a)
  );

  rs232_rx_cfg #(.P_CLKS_PER_BIT(CPB), .P_DATA_BITS(7), .P_PARITY(1), .P_STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_fifo_data(data_b), .rx_fifo_wr_en(wr_b),
    .rx_fifo_full(full_b), .err_parity(perr_b), .err_frame(ferr_b), .err_overrun(ovr_b),
    .rx_break(brk_b), .dbg_state(dbg_b)
  );

  // Record every cycle in which any output strobe is high.
  always @(negedge clk) begin
    if (wr_a | perr_a | ferr_a | ovr_a | brk_a)
      obs_a_q.push_back({wr_a, perr_a, ferr_a, ovr_a, brk_a, wr_a ? {1'b0, data_a} : 9'd0});
    if (wr_b | perr_b | ferr_b | ovr_b | brk_b)
      obs_b_q.push_back({wr_b, perr_b, ferr_b, ovr_b, brk_b, wr_b ? {2'b00, data_b} : 9'd0});
  end

  // ---------------- reference model ----------------
  // Outcome of one frame, from the line-level description of the character.
  function automatic logic [EW-1:0] predict(input logic [8:0] data, input int pmode,
                                            input logic pbit, input logic [1:0] stops,
                                            input int nstop, input logic full);
    logic any_low;
    logic good_p;
    logic perr;
    any_low = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) any_low = 1'b1;
    good_p = ($countones(data) % 2 == 1);
    if (pmode == 2) good_p = ~good_p;
    if (any_low) begin
      if (data == 9'd0 && (pmode == 0 || pbit == 1'b0)) return {5'b00001, 9'd0};
      return {5'b00100, 9'd0};
    end
    if (full) return {5'b00010, 9'd0};
    perr = (pmode != 0) && (pbit != good_p);
    return {1'b1, perr, 3'b000, data};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_events(input int which, input string tag);
    #1;
    if (which == 0) begin
      check({tag, "_count_a"}, obs_a_q.size(), exp_a_q.size());
      while (obs_a_q.size() > 0 && exp_a_q.size() > 0)
        check({tag, "_event_a"}, 32'(obs_a_q.pop_front()), 32'(exp_a_q.pop_front()));
      obs_a_q.delete();
      exp_a_q.delete();
      check({tag, "_hold_a"}, 32'(data_a), 32'(last_a));
    end else begin
      check({tag, "_count_b"}, obs_b_q.size(), exp_b_q.size());
      while (obs_b_q.size() > 0 && exp_b_q.size() > 0)
        check({tag, "_event_b"}, 32'(obs_b_q.pop_front()), 32'(exp_b_q.pop_front()));
      obs_b_q.delete();
      exp_b_q.delete();
      check({tag, "_hold_b"}, 32'(data_b), 32'(last_b));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic b, input int cycles);
    if (which == 0) rx_a = b; else rx_b = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int which, input int nbits);
    drive(which, 1'b1, nbits * CPB);
  endtask

  // Send one frame on instance a (8N1) or b (7E2) and check its outcome.
  task automatic tx(input int which, input logic [8:0] data, input logic pbit,
                    input logic [1:0] stops, input logic full, input string tag);
    int nd, pmode, nstop;
    logic [8:0] d;
    logic [EW-1:0] e;
    nd    = (which == 0) ? 8 : 7;
    pmode = (which == 0) ? 0 : 1;
    nstop = (which == 0) ? 1 : 2;
    d     = data & 9'((1 << nd) - 1);
    e     = predict(d, pmode, pbit, stops, nstop, full);
    if (which == 0) begin
      full_a = full;
      exp_a_q.push_back(e);
      if (e[EW-1]) last_a = d[7:0];
    end else begin
      full_b = full;
      exp_b_q.push_back(e);
      if (e[EW-1]) last_b = d[6:0];
    end
    drive(which, 1'b0, CPB);
    for (int i = 0; i < nd; i++) drive(which, d[i], CPB);
    if (pmode != 0) drive(which, pbit, CPB);
    for (int i = 0; i < nstop; i++) drive(which, stops[i], CPB);
    compare_events(which, tag);
    if (which == 0) full_a = 1'b0; else full_b = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_strobes_a"}, {27'd0, wr_a, perr_a, ferr_a, ovr_a, brk_a}, 32'd0);
    check({tag, "_strobes_b"}, {27'd0, wr_b, perr_b, ferr_b, ovr_b, brk_b}, 32'd0);
    check({tag, "_data_a"}, 32'(data_a), 32'd0);
    check({tag, "_data_b"}, 32'(data_b), 32'd0);
    check({tag, "_state_a"}, 32'(dbg_a), 32'(S_IDLE));
    check({tag, "_state_b"}, 32'(dbg_b), 32'(S_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int which, nidle;
    logic [8:0] d;
    logic [1:0] st;
    logic pb, fl, lastbit;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    idle(0, 2);

    // 8N1 basic character
    tx(0, 9'h0A5, 1'b0, 2'b11, 1'b0, "basic_a5");
    idle(0, 1);

    // false start: 5 clocks low, then a normal character
    drive(0, 1'b0, 5);
    idle(0, 2);
    compare_events(0, "false_start");
    tx(0, 9'h03C, 1'b0, 2'b11, 1'b0, "after_false_3c");

    // 7E2: wrong and correct parity bit
    tx(1, 9'h041, 1'b1, 2'b11, 1'b0, "par_bad_41");
    tx(1, 9'h041, 1'b0, 2'b11, 1'b0, "par_good_41");

    // overrun then normal write
    tx(0, 9'h05A, 1'b0, 2'b11, 1'b1, "overrun_5a");
    tx(0, 9'h05A, 1'b0, 2'b11, 1'b0, "write_5a");

    // framing errors on each instance
    tx(0, 9'h033, 1'b0, 2'b10, 1'b0, "frame_a");
    idle(0, 1);
    tx(1, 9'h033, 1'b0, 2'b01, 1'b0, "frame_b_second_stop");
    idle(1, 1);

    // long break on a, then recovery
    exp_a_q.push_back({5'b00001, 9'd0});
    drive(0, 1'b0, 20 * CPB);
    idle(0, 2);
    compare_events(0, "break_a");
    tx(0, 9'h055, 1'b0, 2'b11, 1'b0, "after_break_55");

    // break on the parity instance
    tx(1, 9'h000, 1'b0, 2'b00, 1'b0, "break_b");
    idle(1, 2);

    // reset during data bit 3 of 0xFF
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 3 * CPB + CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    last_a = 8'h00;
    last_b = 7'h00;
    idle(0, 2);
    compare_events(0, "aborted_ff");
    tx(0, 9'h081, 1'b0, 2'b11, 1'b0, "after_reset_81");
    idle(0, 1);

    // random frames, including back-to-back and error cases
    for (int i = 0; i < 40; i++) begin
      which = int'($urandom_range(0, 1));
      d     = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      st    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      pb    = (which == 1) ? ((^d[6:0]) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
      fl    = ($urandom_range(0, 3) == 0);
      tx(which, d, pb, st, fl, "random");
      lastbit = (which == 0) ? st[0] : st[1];
      nidle   = lastbit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      idle(which, nidle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rs232_rx_cfg.md
RS232_RX_CFG -- requirements
Module: rs232_rx_cfg

Interface
REQ-001 SHALL have parameter P_CLKS_PER_BIT, default 20, clk cycles per bit period; legal range >= 4.
REQ-002 SHALL have parameter P_DATA_BITS, default 8, data bits per character; legal range 5..9.
REQ-003 SHALL have parameter P_PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter P_STOP_BITS, default 1, stop bits checked per character; legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rx_fifo_data  output  P_DATA_BITS  received character, LSB first on line.
REQ-009 SHALL have port rx_fifo_wr_en  output  1  one-cycle write strobe to downstream FIFO.
REQ-010 SHALL have port rx_fifo_full  input  1  downstream FIFO full; write suppressed while high.
REQ-011 SHALL have port err_parity  output  1  one-cycle pulse: parity mismatch on the character being written.
REQ-012 SHALL have port err_frame  output  1  one-cycle pulse: a stop bit sampled low (non-break).
REQ-013 SHALL have port err_overrun  output  1  one-cycle pulse: valid character dropped because rx_fifo_full was high.
REQ-014 SHALL have port rx_break  output  1  one-cycle pulse: break condition detected.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer (rx_s), then a falling-edge detector on rx_s.
REQ-016 SHALL implement states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK.
REQ-017 S_IDLE: clear bit counter and bit-period counter; on rx_s falling edge go to S_START.
REQ-018 S_START: count P_CLKS_PER_BIT/2 cycles (integer division), then sample rx_s; low -> S_DATA with period counter cleared; high -> false start, S_IDLE, no outputs asserted.
REQ-019 S_DATA: sample rx_s every P_CLKS_PER_BIT cycles; shift into shift register LSB-first; after P_DATA_BITS samples go to S_PARITY if P_PARITY != 0, else S_STOP.
REQ-020 S_PARITY: sample one bit after P_CLKS_PER_BIT cycles; mismatch flag = (XOR of data bits XOR parity bit) != (P_PARITY == 2).
REQ-021 S_STOP: sample P_STOP_BITS bits, P_CLKS_PER_BIT cycles apart; after the last sample go to S_IDLE, or S_BRK on break.
REQ-022 Break SHALL be: all data bits 0, parity bit 0 (if present), and any stop bit 0; this raises rx_break, not err_frame, with no write.
REQ-023 Any stop bit 0 without break SHALL raise err_frame with no write and no err_parity.
REQ-024 S_BRK: remain until rx_s == 1, then S_IDLE; falling edges ignored while in S_BRK.
REQ-025 All stop bits 1 and rx_fifo_full == 0: rx_fifo_wr_en = 1 and rx_fifo_data = character for exactly one cycle, the cycle after the last stop sample; err_parity pulses in the same cycle if mismatched.
REQ-026 All stop bits 1 and rx_fifo_full == 1: no write, err_overrun pulses in the cycle after the last stop sample; parity not reported.
REQ-027 rx_fifo_data SHALL hold its value between writes; the parity bit is not included.
REQ-028 The bit-period counter SHALL be clog2(P_CLKS_PER_BIT) bits wide and wrap to 0 at P_CLKS_PER_BIT-1.
REQ-029 A new start edge SHALL be accepted in the first S_IDLE cycle after the last stop sample, so back-to-back characters are received without loss.
REQ-030 At most one of err_frame, err_overrun, rx_break SHALL be asserted per character.

Reset
REQ-031 While rst is high at a clock edge, all state SHALL clear: fsm = S_IDLE, counters 0, shift register 0, rx_fifo_data 0, all strobes and error outputs 0, synchronizer flops 1.
REQ-032 Reset mid-frame SHALL abandon the character with no strobe; the next full frame after release SHALL be received correctly.

Structure
REQ-033 State encodings and parity-mode constants (NONE/EVEN/ODD) SHALL live in shared package rs232_pkg.
REQ-034 Synchronizer plus edge detector SHALL be one sub-module, rs232_rx_front (outputs rx_s, rx_s_nedge).

Verification
REQ-035 P_CLKS_PER_BIT=16, 8N1, send 0xA5 -> single rx_fifo_wr_en, data 0xA5, no error pulses.
REQ-036 rx low for 5 clk then high (16 clk/bit) -> no strobes; next frame 0x3C is received correctly.
REQ-037 7E2 config, send 0x41 with parity bit 1 -> wr_en with data 0x41 and err_parity in the same cycle.
REQ-038 8N1, rx_fifo_full=1, send 0x5A -> err_overrun pulse, no wr_en; full=0, send 0x5A -> written.
REQ-039 rx low for 20 bit times -> exactly one rx_break, no wr_en or err_frame; after rx goes high, 0x55 is received correctly.
REQ-040 rst pulsed during data bit 3 of 0xFF -> all outputs 0, no strobe; following 0x81 is received correctly.
